// File: rtl/pb_cmd_decoder_if.sv
// Button-to-command bus: raw buttons in, debounced levels and mode/divider commands out.
// The decoder owns the slave side; the master side drives pb_in and observes the commands.
interface pb_cmd_decoder_if #(
   parameter int NPB = 21
);
   logic [NPB-1:0] pb_in;
   logic [NPB-1:0] pb_stable;
   logic [2:0]     mode;
   logic           mode_change;
   logic [7:0]     divider;
   logic           div_change;

   modport master (
      output pb_in,
      input  pb_stable, mode, mode_change, divider, div_change
   );

   modport slave (
      input  pb_in,
      output pb_stable, mode, mode_change, divider, div_change
   );
endinterface

// File: rtl/pb_cmd_decoder.sv
// Push-button front end for the idle animation: sync, debounce, rising-edge detect,
// auto-repeat of the speed buttons, and saturating mode/divider command registers.
module pb_cmd_decoder #(
   parameter int NPB          = 21,
   parameter int DEBOUNCE     = 3,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10,
   parameter int DIV_STEP     = 2,
   parameter int DIV_MIN      = 0,
   parameter int DIV_MAX      = 20,
   parameter int DIV_RESET    = 2
) (
   input logic             clk,
   input logic             reset,
   pb_cmd_decoder_if.slave bus
);
   localparam int DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   logic [NPB-1:0] sync1, sync2, stable, stable_q, rise;
   logic [DW-1:0]  db_cnt [NPB];
   logic [RW-1:0]  rep_cnt [2];
   logic [1:0]     rep_first;
   logic [1:0]     spd_stable, spd_rise, spd_fire;
   logic           up_ev, dn_ev, sel_ok;
   logic [2:0]     mode, mode_idx;
   logic           mode_change, div_change;
   logic [7:0]     divider, div_next;
   logic [8:0]     div_up, div_dn;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_q <= '0;
         for (int i = 0; i < NPB; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= bus.pb_in;
         sync2    <= sync1;
         stable_q <= stable;
         for (int i = 0; i < NPB; i++) begin
            if (sync2[i] != stable[i]) begin
               if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                  stable[i] <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign rise = stable & ~stable_q;

   // Index 0 is the up button (pb[8]), index 1 the down button (pb[11]).
   always_comb begin
      spd_stable = {stable[11], stable[8]};
      spd_rise   = {rise[11], rise[8]};
      for (int b = 0; b < 2; b++) begin
         spd_fire[b] = spd_stable[b] & ~spd_rise[b] &
                       (rep_cnt[b] == (rep_first[b] ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));
      end
      up_ev = spd_rise[0] | spd_fire[0];
      dn_ev = spd_rise[1] | spd_fire[1];
   end

   // rep_cnt holds the number of cycles since the last event on that button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) rep_cnt[b] <= '0;
         rep_first <= '1;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (spd_rise[b] || spd_fire[b]) begin
               rep_cnt[b]   <= RW'(1);
               rep_first[b] <= spd_rise[b];
            end else if (!spd_stable[b]) begin
               rep_cnt[b]   <= '0;
               rep_first[b] <= 1'b1;
            end else begin
               rep_cnt[b]   <= rep_cnt[b] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      mode_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (stable[i]) mode_idx = 3'(i);
      end
      sel_ok = (|rise[7:0]) && $onehot(stable[7:0]);

      div_up   = {1'b0, divider} + 9'(DIV_STEP);
      div_dn   = ({1'b0, divider} < 9'(DIV_MIN + DIV_STEP)) ? 9'(DIV_MIN)
                                                            : {1'b0, divider} - 9'(DIV_STEP);
      div_next = divider;
      if (up_ev && !dn_ev) begin
         div_next = (div_up > 9'(DIV_MAX)) ? 8'(DIV_MAX) : div_up[7:0];
      end else if (dn_ev && !up_ev) begin
         div_next = div_dn[7:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode        <= '0;
         mode_change <= 1'b0;
         divider     <= 8'(DIV_RESET);
         div_change  <= 1'b0;
      end else begin
         mode_change <= sel_ok;
         if (sel_ok) mode <= mode_idx;
         divider     <= div_next;
         div_change  <= (div_next != divider);
      end
   end

   assign bus.pb_stable   = stable;
   assign bus.mode        = mode;
   assign bus.mode_change = mode_change;
   assign bus.divider     = divider;
   assign bus.div_change  = div_change;
endmodule

// File: tb/tb_pb_cmd_decoder.sv
// Directed bench for pb_cmd_decoder: latency, glitch rejection, mode select,
// divider saturation, auto-repeat timing and reset behaviour.
module tb_pb_cmd_decoder;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   int   mc_cnt;
   int   dc_cnt;
   int   snap_mc;
   int   snap_dc;

   pb_cmd_decoder_if #(.NPB(21)) bus ();

   pb_cmd_decoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Background pulse counters.
   always @(negedge clk) begin
      if (bus.mode_change) mc_cnt++;
      if (bus.div_change) dc_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tap_up();
      bus.pb_in[8] = 1'b1;
      tick(6);
      bus.pb_in[8] = 1'b0;
      tick(6);
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      mc_cnt = 0;
      dc_cnt = 0;
      reset  = 1'b1;
      bus.pb_in = '0;
      tick(3);
      check("rst_pb_stable", 32'(bus.pb_stable), 0);
      check("rst_mode", 32'(bus.mode), 0);
      check("rst_divider", 32'(bus.divider), 2);
      check("rst_mode_change", 32'(bus.mode_change), 0);
      check("rst_div_change", 32'(bus.div_change), 0);
      reset = 1'b0;
      tick(2);

      // Hold pb[3]: stable after E+4, mode after E+5.
      bus.pb_in[3] = 1'b1;
      tick(4);
      check("pb3_stable_e3", 32'(bus.pb_stable[3]), 0);
      tick(1);
      check("pb3_stable_e4", 32'(bus.pb_stable[3]), 1);
      check("pb3_mode_e4", 32'(bus.mode), 0);
      tick(1);
      check("pb3_mode_e5", 32'(bus.mode), 3);
      check("pb3_mc_e5", 32'(bus.mode_change), 1);
      tick(1);
      check("pb3_mc_e6", 32'(bus.mode_change), 0);
      check("pb3_mode_e6", 32'(bus.mode), 3);
      bus.pb_in[3] = 1'b0;
      tick(10);
      check("pb3_release_stable", 32'(bus.pb_stable), 0);
      check("pb3_release_mode", 32'(bus.mode), 3);

      // Re-selecting the current mode still pulses.
      bus.pb_in[3] = 1'b1;
      tick(6);
      check("reselect_mc", 32'(bus.mode_change), 1);
      check("reselect_mode", 32'(bus.mode), 3);
      bus.pb_in[3] = 1'b0;
      tick(10);

      // Two-cycle glitch on pb[5] never reaches pb_stable.
      snap_mc = mc_cnt;
      bus.pb_in[5] = 1'b1;
      tick(2);
      bus.pb_in[5] = 1'b0;
      tick(20);
      check("glitch_stable", 32'(bus.pb_stable), 0);
      check("glitch_mode", 32'(bus.mode), 3);
      check("glitch_mc_pulses", 32'(mc_cnt - snap_mc), 0);

      // Two mode buttons at once: no change.
      snap_mc = mc_cnt;
      bus.pb_in[1] = 1'b1;
      bus.pb_in[2] = 1'b1;
      tick(15);
      check("dual_stable", 32'(bus.pb_stable), 32'h6);
      check("dual_mode", 32'(bus.mode), 3);
      check("dual_mc_pulses", 32'(mc_cnt - snap_mc), 0);
      bus.pb_in[1] = 1'b0;
      bus.pb_in[2] = 1'b0;
      tick(10);

      // Twelve taps on the up button: 4..20 then saturates.
      snap_dc = dc_cnt;
      for (int t = 0; t < 12; t++) begin
         tap_up();
         if (t == 0) check("up_first_tap", 32'(bus.divider), 4);
      end
      check("up_saturated", 32'(bus.divider), 20);
      check("up_dc_pulses", 32'(dc_cnt - snap_dc), 9);

      // Hold down button: step at rise, repeat at +50, then every 10.
      snap_dc = dc_cnt;
      bus.pb_in[11] = 1'b1;
      tick(5);
      check("dn_before_rise", 32'(bus.divider), 20);
      tick(1);
      check("dn_rise_step", 32'(bus.divider), 18);
      check("dn_rise_dc", 32'(bus.div_change), 1);
      tick(49);
      check("dn_before_rep1", 32'(bus.divider), 18);
      tick(1);
      check("dn_rep1", 32'(bus.divider), 16);
      check("dn_rep1_dc", 32'(bus.div_change), 1);
      tick(9);
      check("dn_before_rep2", 32'(bus.divider), 16);
      tick(1);
      check("dn_rep2", 32'(bus.divider), 14);
      tick(69);
      check("dn_before_zero", 32'(bus.divider), 2);
      tick(1);
      check("dn_zero", 32'(bus.divider), 0);
      tick(65);
      check("dn_hold_zero", 32'(bus.divider), 0);
      check("dn_dc_pulses", 32'(dc_cnt - snap_dc), 10);
      bus.pb_in[11] = 1'b0;
      tick(10);

      // Up and down together, plus a mode button in the same cycle.
      tap_up();
      tap_up();
      check("pre_both_div", 32'(bus.divider), 4);
      snap_dc = dc_cnt;
      bus.pb_in[8]  = 1'b1;
      bus.pb_in[11] = 1'b1;
      bus.pb_in[6]  = 1'b1;
      tick(6);
      check("both_mode", 32'(bus.mode), 6);
      check("both_mc", 32'(bus.mode_change), 1);
      check("both_div", 32'(bus.divider), 4);
      tick(60);
      check("both_div_held", 32'(bus.divider), 4);
      check("both_dc_pulses", 32'(dc_cnt - snap_dc), 0);

      // Reset mid-hold acts immediately; held buttons are then fresh presses.
      reset = 1'b1;
      #1;
      check("midrst_mode", 32'(bus.mode), 0);
      check("midrst_div", 32'(bus.divider), 2);
      check("midrst_stable", 32'(bus.pb_stable), 0);
      check("midrst_mc", 32'(bus.mode_change), 0);
      tick(2);
      reset = 1'b0;
      tick(5);
      check("post_rst_mode_e4", 32'(bus.mode), 0);
      tick(1);
      check("post_rst_mode_e5", 32'(bus.mode), 6);
      check("post_rst_div", 32'(bus.divider), 2);
      bus.pb_in = '0;
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
